// File: rtl/float_discriminant_distributor.sv
// Round-robin dispatcher for a bank of float_discriminant workers that
// re-emits worker results upstream strictly in request order.
module float_discriminant_distributor #(
  parameter int N    = 4,
  parameter int FLEN = 64
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      arg_vld,
  input  logic [FLEN-1:0]           a,
  input  logic [FLEN-1:0]           b,
  input  logic [FLEN-1:0]           c,
  output logic                      busy,
  output logic                      res_vld,
  output logic [FLEN-1:0]           res,
  output logic                      res_negative,
  output logic                      err,
  output logic [$clog2(N+1)-1:0]    in_flight,
  output logic [N-1:0]              wrk_arg_vld,
  output logic [FLEN-1:0]           wrk_a,
  output logic [FLEN-1:0]           wrk_b,
  output logic [FLEN-1:0]           wrk_c,
  input  logic [N-1:0]              wrk_busy,
  input  logic [N-1:0]              wrk_res_vld,
  input  logic [N-1:0][FLEN-1:0]    wrk_res,
  input  logic [N-1:0]              wrk_res_negative,
  input  logic [N-1:0]              wrk_err
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;
  localparam int CW = $clog2(N + 1);

  // Handshake: a request is taken in any cycle where arg_vld && !busy; the
  // chosen worker sees wrk_arg_vld in that same cycle. res_vld is a 1-cycle
  // pulse with no backpressure.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } slot_state_t;

  slot_state_t      r_state [N];
  logic [FLEN-1:0]  r_buf_res [N];
  logic [N-1:0]     r_buf_neg;
  logic [N-1:0]     r_buf_err;
  logic [PW-1:0]    r_disp_ptr;
  logic [PW-1:0]    r_coll_ptr;
  logic [CW-1:0]    r_in_flight;
  logic             r_res_vld;
  logic [FLEN-1:0]  r_res;
  logic             r_res_negative;
  logic             r_err;

  logic             w_busy;
  logic             w_accept;
  logic             w_collect;

  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    return (p == PW'(N - 1)) ? '0 : p + 1'b1;
  endfunction

  // The dispatch pointer never skips a blocked slot, so slot order == request order.
  assign w_busy    = (r_state[r_disp_ptr] != S_IDLE) || wrk_busy[r_disp_ptr];
  assign w_accept  = arg_vld && !w_busy;
  assign w_collect = (r_state[r_coll_ptr] == S_DONE);

  always_comb begin
    wrk_arg_vld = '0;
    if (w_accept) wrk_arg_vld[r_disp_ptr] = 1'b1;
  end

  assign busy         = w_busy;
  assign wrk_a        = a;
  assign wrk_b        = b;
  assign wrk_c        = c;
  assign res_vld      = r_res_vld;
  assign res          = r_res;
  assign res_negative = r_res_negative;
  assign err          = r_err;
  assign in_flight    = r_in_flight;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N; i++) r_state[i] <= S_IDLE;
      r_disp_ptr     <= '0;
      r_coll_ptr     <= '0;
      r_in_flight    <= '0;
      r_res_vld      <= 1'b0;
      r_res          <= '0;
      r_res_negative <= 1'b0;
      r_err          <= 1'b0;
    end else begin
      for (int i = 0; i < N; i++) begin
        case (r_state[i])
          S_IDLE:  if (w_accept && r_disp_ptr == PW'(i)) r_state[i] <= S_RUN;
          S_RUN:   if (wrk_res_vld[i]) r_state[i] <= S_DONE;
          S_DONE:  if (w_collect && r_coll_ptr == PW'(i)) r_state[i] <= S_IDLE;
          default: r_state[i] <= S_IDLE;
        endcase
      end
      if (w_accept) r_disp_ptr <= ptr_next(r_disp_ptr);
      if (w_collect) begin
        r_coll_ptr     <= ptr_next(r_coll_ptr);
        r_res          <= r_buf_res[r_coll_ptr];
        r_res_negative <= r_buf_neg[r_coll_ptr];
        r_err          <= r_buf_err[r_coll_ptr];
      end
      r_res_vld   <= w_collect;
      r_in_flight <= r_in_flight + CW'(w_accept) - CW'(w_collect);
    end
  end

  // Results are only captured by a slot that is waiting for one; stray
  // strobes on IDLE or DONE slots are dropped.
  always_ff @(posedge clk) begin
    for (int i = 0; i < N; i++) begin
      if (r_state[i] == S_RUN && wrk_res_vld[i]) begin
        r_buf_res[i] <= wrk_res[i];
        r_buf_neg[i] <= wrk_res_negative[i];
        r_buf_err[i] <= wrk_err[i];
      end
    end
  end

endmodule
